l2_ecc_scrubber: RTL and testbench

//  TCDM initiator that walks one ECC-protected L2 bank, one read at a time, and writes back rdata on correctable errors.

---
 rtl/l2_scrub_pkg.sv | 26 ++
 rtl/l2_scrub_sat_cnt.sv | 24 ++
 rtl/l2_ecc_scrubber.sv | 191 +++++++++++++++++++
 tb/tb_l2_ecc_scrubber.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_scrub_pkg.sv
// Shared types and constants for the L2 ECC scrubber.
package l2_scrub_pkg;

  localparam int unsigned CNT_WIDTH      = 16;
  localparam int unsigned ERR_CORR_BIT   = 0;
  localparam int unsigned ERR_UNCORR_BIT = 1;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BE_WIDTH       = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_RSP = 3'd3,
    S_WR_REQ = 3'd4,
    S_WR_RSP = 3'd5
  } scrub_state_e;

  // Byte address of a 32-bit word inside the bank.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ADDR_WIDTH-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/l2_scrub_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module l2_scrub_sat_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Count increments, stopping at the maximum value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/l2_ecc_scrubber.sv
// L2 ECC scrubber: walks one ECC-protected bank over TCDM, one read at a
// time, writing corrected data back when the bank flags a correctable error.
// Optional interrupt on uncorrectable errors when L2_SCRUB_IRQ_EN is defined.
module l2_ecc_scrubber
  import l2_scrub_pkg::*;
#(
  parameter int unsigned     BANK_SIZE = 32768,
  parameter logic [31:0]     BASE_ADDR = 32'h1C00_0000,
  parameter int unsigned     IVL_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [IVL_WIDTH-1:0]  interval_i,
  input  logic                  sys_req_i,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_WIDTH-1:0] tcdm_wdata_o,
  output logic [BE_WIDTH-1:0]   tcdm_be_o,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_rdata_i,
  input  logic [1:0]            ecc_err_i,
`ifdef L2_SCRUB_IRQ_EN
  input  logic                  irq_clr_i,
  output logic                  uncorr_irq_o,
`endif
  output logic                  busy_o,
  output logic                  sweep_done_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic [ADDR_WIDTH-1:0] uncorr_addr_o
);

  localparam int unsigned IDX_W = $clog2(BANK_SIZE);

  scrub_state_e          r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IVL_WIDTH-1:0]  r_ivl_cnt;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_add;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  r_busy;
  logic                  r_sweep_done;
  logic [ADDR_WIDTH-1:0] r_uncorr_addr;

  logic w_rd_done;
  logic w_uncorr_inc;
  logic w_wb_start;
  logic w_corr_inc;
  logic w_advance;
  logic w_wrap;

  // Response decode: which event ends the current word.
  assign w_rd_done    = (r_state == S_RD_RSP) && tcdm_r_valid_i;
  assign w_uncorr_inc = w_rd_done && ecc_err_i[ERR_UNCORR_BIT];
  assign w_wb_start   = w_rd_done && !ecc_err_i[ERR_UNCORR_BIT] && ecc_err_i[ERR_CORR_BIT];
  assign w_corr_inc   = (r_state == S_WR_RSP) && tcdm_r_valid_i;
  assign w_advance    = (w_rd_done && !w_wb_start) || w_corr_inc;
  assign w_wrap       = (r_idx == IDX_W'(BANK_SIZE - 1));

  // Scrub FSM with registered TCDM request outputs; advance overrides the case.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_ivl_cnt     <= '0;
      r_req         <= 1'b0;
      r_add         <= '0;
      r_wen         <= 1'b1;
      r_wdata       <= '0;
      r_be          <= '0;
      r_busy        <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_uncorr_addr <= '0;
    end else begin
      r_sweep_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state   <= S_WAIT;
            r_ivl_cnt <= interval_i;
            r_busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!enable_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_ivl_cnt == '0) begin
            if (!sys_req_i) begin
              r_state <= S_RD_REQ;
              r_req   <= 1'b1;
              r_wen   <= 1'b1;
              r_be    <= {BE_WIDTH{1'b1}};
              r_add   <= word_addr(BASE_ADDR, ADDR_WIDTH'(r_idx));
            end
          end else begin
            r_ivl_cnt <= r_ivl_cnt - IVL_WIDTH'(1);
          end
        end
        S_RD_REQ: begin
          if (tcdm_gnt_i) begin
            r_state <= S_RD_RSP;
            r_req   <= 1'b0;
            r_be    <= '0;
          end
        end
        S_RD_RSP: begin
          if (w_uncorr_inc) begin
            r_uncorr_addr <= r_add;
          end else if (w_wb_start) begin
            r_state <= S_WR_REQ;
            r_wdata <= tcdm_r_rdata_i;
            r_req   <= 1'b1;
            r_wen   <= 1'b0;
            r_be    <= {BE_WIDTH{1'b1}};
          end
        end
        S_WR_REQ: begin
          if (tcdm_gnt_i) begin
            r_state <= S_WR_RSP;
            r_req   <= 1'b0;
            r_wen   <= 1'b1;
            r_be    <= '0;
          end
        end
        S_WR_RSP: begin
          // Completion handled by the advance path below.
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_advance) begin
        r_idx        <= w_wrap ? '0 : r_idx + IDX_W'(1);
        r_sweep_done <= w_wrap;
        r_busy       <= enable_i;
        r_ivl_cnt    <= interval_i;
        r_state      <= enable_i ? S_WAIT : S_IDLE;
      end
    end
  end

  // Error counters.
  l2_scrub_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_corr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_corr_inc),
    .cnt_o (corr_cnt_o)
  );

  l2_scrub_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_uncorr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_uncorr_inc),
    .cnt_o (uncorr_cnt_o)
  );

`ifdef L2_SCRUB_IRQ_EN
  logic r_irq;

  // Sticky uncorrectable interrupt; a new event wins over a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else if (w_uncorr_inc) begin
      r_irq <= 1'b1;
    end else if (irq_clr_i) begin
      r_irq <= 1'b0;
    end
  end

  assign uncorr_irq_o = r_irq;
`endif

  assign tcdm_req_o    = r_req;
  assign tcdm_add_o    = r_add;
  assign tcdm_wen_o    = r_wen;
  assign tcdm_wdata_o  = r_wdata;
  assign tcdm_be_o     = r_be;
  assign busy_o        = r_busy;
  assign sweep_done_o  = r_sweep_done;
  assign uncorr_addr_o = r_uncorr_addr;

endmodule

// File: tb/tb_l2_ecc_scrubber.sv
// Bench for l2_ecc_scrubber with a 4-word bank model and a transaction scoreboard.
module tb_l2_ecc_scrubber;

  localparam int unsigned BANK = 4;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] interval;
  logic        sys_req;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [31:0] tcdm_wdata;
  logic [3:0]  tcdm_be;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic [1:0]  ecc_err;
  logic        busy;
  logic        sweep_done;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic [31:0] uncorr_addr;
`ifdef L2_SCRUB_IRQ_EN
  logic        irq_clr;
  logic        uncorr_irq;
`endif

  l2_ecc_scrubber #(
    .BANK_SIZE (BANK),
    .BASE_ADDR (BASE),
    .IVL_WIDTH (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .interval_i     (interval),
    .sys_req_i      (sys_req),
    .tcdm_req_o     (tcdm_req),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_add_o     (tcdm_add),
    .tcdm_wen_o     (tcdm_wen),
    .tcdm_wdata_o   (tcdm_wdata),
    .tcdm_be_o      (tcdm_be),
    .tcdm_r_valid_i (r_valid),
    .tcdm_r_rdata_i (r_rdata),
    .ecc_err_i      (ecc_err),
`ifdef L2_SCRUB_IRQ_EN
    .irq_clr_i      (irq_clr),
    .uncorr_irq_o   (uncorr_irq),
`endif
    .busy_o         (busy),
    .sweep_done_o   (sweep_done),
    .corr_cnt_o     (corr_cnt),
    .uncorr_cnt_o   (uncorr_cnt),
    .uncorr_addr_o  (uncorr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model knobs.
  logic        gnt_allow;
  logic        block_wr;
  logic        stray_req;
  logic [7:0]  cur_err;
  int          cur_hot;
  logic [31:0] cur_rd;

  assign tcdm_gnt = tcdm_req & gnt_allow & (tcdm_wen | ~block_wr);

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];

  int n_cmp;
  int n_fail;
  int sweep_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_data(input int w);
    return (w == cur_hot) ? cur_rd : 32'h0000_1000 + 32'(w);
  endfunction

  // Handshake capture at the edge where the request is accepted.
  bit          hs_pend;
  logic [31:0] hs_add;
  logic        hs_wen;
  logic [31:0] hs_wdata;
  logic [3:0]  hs_be;

  always @(posedge clk) begin
    if (!rst && tcdm_req && tcdm_gnt) begin
      hs_pend  = 1'b1;
      hs_add   = tcdm_add;
      hs_wen   = tcdm_wen;
      hs_wdata = tcdm_wdata;
      hs_be    = tcdm_be;
    end
  end

  // Scoreboard check and response generation, one cycle after the grant.
  always @(negedge clk) begin
    txn_t        e;
    logic [31:0] off;
    int          w;
    r_valid = 1'b0;
    ecc_err = 2'b00;
    r_rdata = 32'h0;
    if (sweep_done) sweep_cnt++;
    if (stray_req) begin
      stray_req = 1'b0;
      r_valid   = 1'b1;
      ecc_err   = 2'b11;
      r_rdata   = 32'hBAD0_BAD0;
    end else if (hs_pend) begin
      hs_pend = 1'b0;
      if (exp_q.size() == 0) begin
        check("txn_unexpected", hs_add, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("txn_add", hs_add, e.add);
        check("txn_wen", 32'(hs_wen), 32'(e.wen));
        check("txn_be", 32'(hs_be), 32'hF);
        if (!e.wen) check("txn_wdata", hs_wdata, e.wdata);
      end
      r_valid = 1'b1;
      if (hs_wen) begin
        off     = hs_add - BASE;
        w       = int'(off[3:2]);
        r_rdata = word_data(w);
        ecc_err = cur_err[2*w +: 2];
      end
    end
  end

  task automatic push_txn(input int w, input logic wen, input logic [31:0] wd);
    txn_t t;
    t.add   = BASE + 32'(w * 4);
    t.wen   = wen;
    t.wdata = wd;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    enable    = 1'b0;
    sys_req   = 1'b0;
    interval  = 16'd0;
    gnt_allow = 1'b1;
    block_wr  = 1'b0;
    stray_req = 1'b0;
`ifdef L2_SCRUB_IRQ_EN
    irq_clr   = 1'b0;
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    sweep_cnt = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(busy), 32'h0);
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (!tcdm_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(tcdm_req), 32'h1);
  endtask

  typedef struct {
    logic [7:0]  err;
    int          hot;
    logic [31:0] rd;
    int          exp_corr;
    int          exp_uncorr;
    logic [31:0] exp_uaddr;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    n_cmp     = 0;
    n_fail    = 0;
    sweep_cnt = 0;
    hs_pend   = 1'b0;
    cur_err   = 8'h00;
    cur_hot   = -1;
    cur_rd    = 32'h0;

    // err packed as {w3,w2,w1,w0}
    vecs[0] = '{err: 8'b00_00_00_00, hot: -1, rd: 32'h0,         exp_corr: 0, exp_uncorr: 0, exp_uaddr: 32'h0};
    vecs[1] = '{err: 8'b00_01_00_00, hot: 2,  rd: 32'hDEADBEEF,  exp_corr: 1, exp_uncorr: 0, exp_uaddr: 32'h0};
    vecs[2] = '{err: 8'b00_00_11_00, hot: -1, rd: 32'h0,         exp_corr: 0, exp_uncorr: 1, exp_uaddr: BASE + 32'h4};
    vecs[3] = '{err: 8'b01_00_00_10, hot: 3,  rd: 32'hCAFEF00D,  exp_corr: 1, exp_uncorr: 1, exp_uaddr: BASE};
    vecs[4] = '{err: 8'b00_11_10_01, hot: 0,  rd: 32'h12345678,  exp_corr: 1, exp_uncorr: 2, exp_uaddr: BASE + 32'h8};

    // Reset state
    do_reset();
    check("rst_req",   32'(tcdm_req), 32'h0);
    check("rst_wen",   32'(tcdm_wen), 32'h1);
    check("rst_be",    32'(tcdm_be), 32'h0);
    check("rst_add",   tcdm_add, 32'h0);
    check("rst_wdata", tcdm_wdata, 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_sweep", 32'(sweep_done), 32'h0);
    check("rst_corr",  32'(corr_cnt), 32'h0);
    check("rst_unc",   32'(uncorr_cnt), 32'h0);
    check("rst_uaddr", uncorr_addr, 32'h0);
`ifdef L2_SCRUB_IRQ_EN
    check("rst_irq",   32'(uncorr_irq), 32'h0);
`endif

    // Full sweeps with error patterns
    foreach (vecs[i]) begin
      do_reset();
      cur_err = vecs[i].err;
      cur_hot = vecs[i].hot;
      cur_rd  = vecs[i].rd;
      for (int w = 0; w < int'(BANK); w++) begin
        push_txn(w, 1'b1, 32'h0);
        if (cur_err[2*w +: 2] == 2'b01) push_txn(w, 1'b0, word_data(w));
      end
      enable = 1'b1;
      k = 0;
      while (!sweep_done && k < 200) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("v%0d_sweep_seen", i), 32'(sweep_done), 32'h1);
      enable = 1'b0;
      wait_idle($sformatf("v%0d_idle", i));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_corr", i), 32'(corr_cnt), 32'(vecs[i].exp_corr));
      check($sformatf("v%0d_unc", i), 32'(uncorr_cnt), 32'(vecs[i].exp_uncorr));
      check($sformatf("v%0d_uaddr", i), uncorr_addr, vecs[i].exp_uaddr);
      check($sformatf("v%0d_leftover", i), 32'(exp_q.size()), 32'h0);
      check($sformatf("v%0d_sweeps", i), 32'(sweep_cnt), 32'h1);
`ifdef L2_SCRUB_IRQ_EN
      check($sformatf("v%0d_irq", i), 32'(uncorr_irq), 32'(vecs[i].exp_uncorr > 0));
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check($sformatf("v%0d_irq_clr", i), 32'(uncorr_irq), 32'h0);
`endif
    end

    // Grant stall with enable dropped mid-request
    do_reset();
    cur_err   = 8'h00;
    cur_hot   = -1;
    gnt_allow = 1'b0;
    push_txn(0, 1'b1, 32'h0);
    enable = 1'b1;
    wait_req("stall_req_seen");
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_req", 32'(tcdm_req), 32'h1);
      check("stall_add", tcdm_add, BASE);
      check("stall_wen", 32'(tcdm_wen), 32'h1);
    end
    gnt_allow = 1'b1;
    @(negedge clk);
    wait_idle("stall_idle");
    repeat (5) @(negedge clk);
    check("stall_no_req", 32'(tcdm_req), 32'h0);
    check("stall_leftover", 32'(exp_q.size()), 32'h0);
    // Index survives the enable toggle
    push_txn(1, 1'b1, 32'h0);
    enable = 1'b1;
    wait_req("resume_req_seen");
    enable = 1'b0;
    @(negedge clk);
    wait_idle("resume_idle");
    repeat (3) @(negedge clk);
    check("resume_leftover", 32'(exp_q.size()), 32'h0);

    // Interval latency, then hold-off by system traffic
    do_reset();
    interval = 16'd3;
    push_txn(0, 1'b1, 32'h0);
    push_txn(1, 1'b1, 32'h0);
    enable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tcdm_req && k < 30);
    check("ivl_latency", 32'(k), 32'd5);
    sys_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("sysreq_hold", 32'(tcdm_req), 32'h0);
    end
    sys_req = 1'b0;
    @(negedge clk);
    check("sysreq_release", 32'(tcdm_req), 32'h1);
    check("sysreq_add", tcdm_add, BASE + 32'h4);
    enable = 1'b0;
    wait_idle("sysreq_idle");
    repeat (3) @(negedge clk);
    check("sysreq_leftover", 32'(exp_q.size()), 32'h0);

    // Reset during write request, then a stale response
    do_reset();
    cur_err  = 8'b00_00_00_01;
    cur_hot  = 0;
    cur_rd   = 32'h5555_AAAA;
    block_wr = 1'b1;
    push_txn(0, 1'b1, 32'h0);
    enable = 1'b1;
    k = 0;
    while (!(tcdm_req && !tcdm_wen) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wrreq_seen", 32'(tcdm_req && !tcdm_wen), 32'h1);
    check("wrreq_wdata", tcdm_wdata, 32'h5555_AAAA);
    check("wrreq_add", tcdm_add, BASE);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(tcdm_req), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_wen", 32'(tcdm_wen), 32'h1);
    rst       = 1'b0;
    block_wr  = 1'b0;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_corr", 32'(corr_cnt), 32'h0);
    check("stray_unc", 32'(uncorr_cnt), 32'h0);
    check("stray_uaddr", uncorr_addr, 32'h0);
    check("stray_busy", 32'(busy), 32'h0);
    check("stray_req", 32'(tcdm_req), 32'h0);
`ifdef L2_SCRUB_IRQ_EN
    check("stray_irq", 32'(uncorr_irq), 32'h0);
`endif
    check("stray_leftover", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
